// File: rtl/rt_alu_arb_if.sv
// Request/response channels between the two ray-tracing requesters and rt_alu_arb.
// Requester r drives slot r of the req_* arrays; rsp_src names the issuing slot.
interface rt_alu_arb_if #(
    parameter int WORD_LEN  = 32,
    parameter int OP_LEN    = 4,
    parameter int NUM_LANES = 3
);
    logic [1:0]                               req_valid;
    logic [1:0]                               req_ready;
    logic [1:0][OP_LEN-1:0]                   req_op;
    logic [1:0][NUM_LANES-1:0][WORD_LEN-1:0]  req_a;
    logic [1:0][NUM_LANES-1:0][WORD_LEN-1:0]  req_b;
    logic                                     rsp_valid;
    logic                                     rsp_ready;
    logic                                     rsp_src;
    logic                                     rsp_err;
    logic [NUM_LANES-1:0][WORD_LEN-1:0]       rsp_out;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_src, rsp_err, rsp_out
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_src, rsp_err, rsp_out
    );
endinterface

// File: rtl/rt_alu_arb.sv
// Round-robin arbiter/sequencer sharing one combinational vector ALU between two requesters.
// Define RT_ALU_ARB_OPCHK_EN to flag opcodes above MUL with rsp_err and a zeroed result.
module rt_alu_arb_lane #(
    parameter int WORD_LEN = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_i,
    input  logic                capture_i,
    input  logic                zero_i,
    input  logic [WORD_LEN-1:0] a_i,
    input  logic [WORD_LEN-1:0] b_i,
    input  logic [WORD_LEN-1:0] res_i,
    output logic [WORD_LEN-1:0] a_o,
    output logic [WORD_LEN-1:0] b_o,
    output logic [WORD_LEN-1:0] res_o
);
    logic [WORD_LEN-1:0] a_q, b_q, res_q;
    logic [WORD_LEN-1:0] a_d, b_d, res_d;

    always_comb begin
        a_d   = issue_i ? a_i : a_q;
        b_d   = issue_i ? b_i : b_q;
        res_d = res_q;
        if (capture_i) res_d = zero_i ? '0 : res_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            res_q <= res_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign res_o = res_q;
endmodule

module rt_alu_arb #(
    parameter int WORD_LEN  = 32,
    parameter int IW        = 16,
    parameter int QW        = 16,
    parameter int OP_LEN    = 4,
    parameter int NUM_LANES = 3
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    rt_alu_arb_if.slave                        bus,
    output logic [OP_LEN-1:0]                  alu_op_o,
    output logic [NUM_LANES-1:0][WORD_LEN-1:0] alu_a_o,
    output logic [NUM_LANES-1:0][WORD_LEN-1:0] alu_b_o,
    input  logic [NUM_LANES-1:0][WORD_LEN-1:0] alu_out_i
);
    if (IW + QW != WORD_LEN) begin : g_fmt_chk
        $error("rt_alu_arb: IW + QW must equal WORD_LEN");
    end

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e            state_q;
    logic              last_q;
    logic              src_q;
    logic              vld_q;
    logic [OP_LEN-1:0] op_q;
    logic              gnt;
    logic              issue;
    logic              capture;
    logic              bad_op;

    // Lower index wins unless it was served last and the other side is also waiting.
    always_comb begin
        gnt           = bus.req_valid[1] & (~bus.req_valid[0] | ~last_q);
        issue         = (state_q == IDLE) && (|bus.req_valid);
        capture       = (state_q == EXEC);
        bus.req_ready = '0;
        if (issue) bus.req_ready[gnt] = 1'b1;
    end

`ifdef RT_ALU_ARB_OPCHK_EN
    logic err_q;
    assign bad_op      = (op_q > OP_LEN'(2));
    assign bus.rsp_err = err_q;
`else
    assign bad_op      = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            src_q   <= 1'b0;
            vld_q   <= 1'b0;
            op_q    <= '0;
`ifdef RT_ALU_ARB_OPCHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (issue) begin
                    op_q    <= bus.req_op[gnt];
                    src_q   <= gnt;
                    last_q  <= gnt;
                    state_q <= EXEC;
                end
                EXEC: begin
`ifdef RT_ALU_ARB_OPCHK_EN
                    err_q   <= bad_op;
`endif
                    vld_q   <= 1'b1;
                    state_q <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    vld_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        rt_alu_arb_lane #(.WORD_LEN(WORD_LEN)) u_lane (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .issue_i   (issue),
            .capture_i (capture),
            .zero_i    (bad_op),
            .a_i       (bus.req_a[gnt][l]),
            .b_i       (bus.req_b[gnt][l]),
            .res_i     (alu_out_i[l]),
            .a_o       (alu_a_o[l]),
            .b_o       (alu_b_o[l]),
            .res_o     (bus.rsp_out[l])
        );
    end

    assign alu_op_o      = op_q;
    assign bus.rsp_valid = vld_q;
    assign bus.rsp_src   = src_q;
endmodule

// File: tb/tb_rt_alu_arb.sv
// Scoreboard bench for rt_alu_arb: a behavioural ALU drives alu_out, a negedge monitor
// predicts grants and results from the requests it sees accepted and checks every response.
module tb_rt_alu_arb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rt_alu_arb_if bus ();
    logic [3:0]       alu_op;
    logic [2:0][31:0] alu_a, alu_b, alu_out;

    rt_alu_arb dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .alu_op_o  (alu_op),
        .alu_a_o   (alu_a),
        .alu_b_o   (alu_b),
        .alu_out_i (alu_out)
    );

    // External combinational ALU: Q16.16 lanes, a passed through for unknown ops.
    logic signed [63:0] prod;
    always_comb begin
        prod    = '0;
        alu_out = '0;
        for (int l = 0; l < 3; l++) begin
            case (alu_op)
                4'd0: alu_out[l] = alu_a[l] + alu_b[l];
                4'd1: alu_out[l] = alu_a[l] - alu_b[l];
                4'd2: begin
                    prod       = $signed(alu_a[l]) * $signed(alu_b[l]);
                    alu_out[l] = prod[47:16];
                end
                default: alu_out[l] = alu_a[l];
            endcase
        end
    end

    typedef struct packed {
        logic             src;
        logic             err;
        logic [2:0][31:0] out;
    } exp_t;

    exp_t exp_q[$];
    bit   gq[$];
    int   n_chk = 0, n_err = 0;
    int   cyc = 0, t_acc = 0, n_rsp = 0, last_acc_cyc = 0, last_rsp_cyc = 0;
    int   n_acc[2];
    bit   busy = 0, last_g = 1, prev_v = 0;
    exp_t prev_rsp, last_rsp;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic exp_t ref_model(input logic src, input logic [3:0] op,
                                       input logic [2:0][31:0] a, input logic [2:0][31:0] b);
        exp_t   e;
        longint x, y, r;
        e.src = src;
        e.err = 1'b0;
        for (int l = 0; l < 3; l++) begin
            x = longint'($signed(a[l]));
            y = longint'($signed(b[l]));
            case (op)
                4'd0:    r = x + y;
                4'd1:    r = x - y;
                4'd2:    r = (x * y) >>> 16;
                default: r = x;
            endcase
            e.out[l] = r[31:0];
        end
`ifdef RT_ALU_ARB_OPCHK_EN
        if (op > 4'd2) begin
            e.err = 1'b1;
            e.out = '0;
        end
`endif
        return e;
    endfunction

    // Monitor: grant model, accept bookkeeping, response scoreboard.
    always @(negedge clk) begin
        logic [1:0] erdy;
        logic       g;
        exp_t       got, e;
        cyc++;
        got.src = bus.rsp_src;
        got.err = bus.rsp_err;
        got.out = bus.rsp_out;
        if (rst) begin
            exp_q.delete();
            busy   = 0;
            last_g = 1;
            prev_v = 0;
        end else begin
            erdy = '0;
            if (!busy) erdy = (&bus.req_valid) ? (last_g ? 2'b01 : 2'b10) : bus.req_valid;
            chk("req_ready", 128'(bus.req_ready), 128'(erdy));
            if (|(bus.req_valid & bus.req_ready)) begin
                g = bus.req_ready[1];
                exp_q.push_back(ref_model(g, bus.req_op[g], bus.req_a[g], bus.req_b[g]));
                gq.push_back(g);
                last_g       = g;
                busy         = 1;
                t_acc        = cyc;
                last_acc_cyc = cyc;
                n_acc[g]     = n_acc[g] + 1;
            end
            if (prev_v) chk("rsp_valid_hold", 128'(bus.rsp_valid), 128'(1));
            if (bus.rsp_valid) begin
                if (!busy || exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 expected 0");
                end else begin
                    if (!prev_v) chk("rsp_latency", 128'(cyc - t_acc), 128'(2));
                    else         chk("rsp_stable", 128'(got), 128'(prev_rsp));
                    e = exp_q[0];
                    chk("rsp_src", 128'(got.src), 128'(e.src));
                    chk("rsp_err", 128'(got.err), 128'(e.err));
                    chk("rsp_out", 128'(got.out), 128'(e.out));
                    if (bus.rsp_ready) begin
                        void'(exp_q.pop_front());
                        busy         = 0;
                        last_rsp     = got;
                        last_rsp_cyc = cyc;
                        n_rsp++;
                    end
                end
            end else if (busy && (cyc - t_acc) > 100) begin
                n_chk++;
                n_err++;
                $display("FAIL rsp_timeout: got no rsp_valid after %0d cycles expected 2", cyc - t_acc);
                busy = 0;
                exp_q.delete();
            end
            prev_v   = bus.rsp_valid && !bus.rsp_ready;
            prev_rsp = got;
        end
    end

    function automatic logic [2:0][31:0] rvec();
        logic [2:0][31:0] v;
        for (int l = 0; l < 3; l++) begin
            v[l] = $urandom();
            if ($urandom_range(0, 1) == 1) v[l] = {{14{v[l][17]}}, v[l][17:0]};
        end
        return v;
    endfunction

    function automatic logic [3:0] rop();
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(3, 15));
        return 4'($urandom_range(0, 2));
    endfunction

    task automatic raise(input int r, input logic [3:0] op,
                         input logic [2:0][31:0] a, input logic [2:0][31:0] b);
        bus.req_valid[r] = 1'b1;
        bus.req_op[r]    = op;
        bus.req_a[r]     = a;
        bus.req_b[r]     = b;
    endtask

    // Returns at posedge+1 just after the handshake edge.
    task automatic wait_acc(input int r, input int start);
        int i = 0;
        while (n_acc[r] == start && i < 200) begin
            @(posedge clk);
            i++;
        end
        #1;
        chk($sformatf("accept_r%0d", r), 128'(n_acc[r] != start), 128'(1));
    endtask

    task automatic wait_idle();
        int i = 0;
        while ((busy || exp_q.size() != 0) && i < 300) begin
            @(posedge clk);
            i++;
        end
        #1;
        chk("drain", 128'(busy || exp_q.size() != 0), 128'(0));
    endtask

    task automatic chk_reset_vals();
        chk("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        chk("rst_rsp_src",   128'(bus.rsp_src),   128'(0));
        chk("rst_rsp_err",   128'(bus.rsp_err),   128'(0));
        chk("rst_rsp_out",   128'(bus.rsp_out),   128'(0));
        chk("rst_alu_op",    128'(alu_op),        128'(0));
        chk("rst_alu_a",     128'(alu_a),         128'(0));
        chk("rst_alu_b",     128'(alu_b),         128'(0));
    endtask

    initial begin
        int s0, s1, g0, i, start_rsp;
        int seen[2];
        n_acc[0] = 0;
        n_acc[1] = 0;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_vals();

        // Single ADD from r0.
        @(posedge clk); #1;
        s0 = n_acc[0];
        raise(0, 4'd0, {32'hFFFF0000, 32'h00020000, 32'h00010000},
                       {32'h00010000, 32'h00010000, 32'h00008000});
        wait_acc(0, s0);
        bus.req_valid[0] = 1'b0;
        wait_idle();
        chk("add_out", 128'(last_rsp.out), 128'({32'h00000000, 32'h00030000, 32'h00018000}));
        chk("add_src", 128'(last_rsp.src), 128'(0));

        // MUL from r1.
        s1 = n_acc[1];
        raise(1, 4'd2, {32'h0, 32'h0, 32'h00020000}, {32'h0, 32'h0, 32'h00030000});
        wait_acc(1, s1);
        bus.req_valid[1] = 1'b0;
        wait_idle();
        chk("mul_lane0", 128'(last_rsp.out[0]), 128'(32'h00060000));
        chk("mul_src",   128'(last_rsp.src),    128'(1));

        // Both requesters valid continuously: grants alternate starting with r0.
        s0 = n_acc[0];
        s1 = n_acc[1];
        g0 = gq.size();
        seen[0] = s0;
        seen[1] = s1;
        raise(0, rop(), rvec(), rvec());
        raise(1, rop(), rvec(), rvec());
        i = 0;
        while ((n_acc[0] + n_acc[1] - s0 - s1) < 4 && i < 300) begin
            @(posedge clk); #1;
            i++;
            for (int r = 0; r < 2; r++)
                if (n_acc[r] != seen[r]) begin
                    seen[r] = n_acc[r];
                    raise(r, rop(), rvec(), rvec());
                end
        end
        bus.req_valid = '0;
        wait_idle();
        chk("alt_count", 128'(gq.size() >= g0 + 4), 128'(1));
        if (gq.size() >= g0 + 4)
            for (int k = 0; k < 4; k++) chk($sformatf("alt_grant%0d", k), 128'(gq[g0+k]), 128'(k % 2));

        // Response back-pressure for 5 cycles, r1 waiting meanwhile.
        bus.rsp_ready = 1'b0;
        s0 = n_acc[0];
        raise(0, 4'd1, rvec(), rvec());
        wait_acc(0, s0);
        bus.req_valid[0] = 1'b0;
        @(posedge clk); #1;
        s1 = n_acc[1];
        raise(1, 4'd0, rvec(), rvec());
        repeat (5) @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        wait_acc(1, s1);
        bus.req_valid[1] = 1'b0;
        chk("accept_after_rsp", 128'(last_acc_cyc - last_rsp_cyc), 128'(1));
        wait_idle();

        // Reset during EXEC of an r0 SUB: result discarded, r0 wins the next tie.
        s0 = n_acc[0];
        raise(0, 4'd1, rvec(), rvec());
        wait_acc(0, s0);
        bus.req_valid[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk); #1;
        s0 = n_acc[0];
        s1 = n_acc[1];
        raise(0, rop(), rvec(), rvec());
        raise(1, rop(), rvec(), rvec());
        wait_acc(0, s0);
        chk("post_rst_first_r1", 128'(n_acc[1] - s1), 128'(0));
        bus.req_valid[0] = 1'b0;
        wait_acc(1, s1);
        bus.req_valid[1] = 1'b0;
        wait_idle();

        // Illegal opcode.
        s0 = n_acc[0];
        raise(0, 4'b0111, {32'h1, 32'h2, 32'h00050000}, rvec());
        wait_acc(0, s0);
        bus.req_valid[0] = 1'b0;
        wait_idle();
`ifdef RT_ALU_ARB_OPCHK_EN
        chk("illegal_err", 128'(last_rsp.err), 128'(1));
        chk("illegal_out", 128'(last_rsp.out), 128'(0));
`else
        chk("illegal_err",   128'(last_rsp.err),    128'(0));
        chk("illegal_lane0", 128'(last_rsp.out[0]), 128'(32'h00050000));
`endif

        // Random traffic with random back-pressure and withdrawals.
        start_rsp = n_rsp;
        seen[0] = n_acc[0];
        seen[1] = n_acc[1];
        for (int c = 0; c < 4000 && (n_rsp - start_rsp) < 40; c++) begin
            @(posedge clk); #1;
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < 2; r++) begin
                if (n_acc[r] != seen[r]) begin
                    seen[r] = n_acc[r];
                    bus.req_valid[r] = 1'b0;
                end
                if (bus.req_valid[r]) begin
                    if ($urandom_range(0, 15) == 0) bus.req_valid[r] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    raise(r, rop(), rvec(), rvec());
                end
            end
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        wait_idle();
        chk("random_rsp_count", 128'((n_rsp - start_rsp) >= 40), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/rt_alu_arb.md
# rt_alu_arb

Round-robin arbiter and sequencer that shares one combinational vector ALU (rt_alu_vec: ops ADD/SUB/MUL on 3-lane signed fixed-point vectors) between two requesters in the ray-tracing core. It accepts one operation at a time over a valid/ready handshake and registers the operands into the ALU. It captures the ALU result and returns it, tagged with the source requester, over a valid/ready response channel.

## Interface
- WORD_LEN, 32: lane width in bits (signed).
- IW, 16: integer bits of the fixed-point format.
- QW, 16: fractional bits; IW+QW must equal WORD_LEN.
- OP_LEN, 4: opcode width.

- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid[2]  in  1 each  request present, requester r.
- req_ready[2]  out  1 each  request accepted this cycle.
- req_op[2]  in  OP_LEN each  opcode: 0 ADD, 1 SUB, 2 MUL.
- req_a[2][3], req_b[2][3]  in  WORD_LEN each  operand vectors.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_src  out  1  index of the requester that issued the result.
- rsp_out[3]  out  WORD_LEN  result vector.
- rsp_err  out  1  illegal opcode flag (see Configuration).
- alu_op  out  OP_LEN  registered opcode to the ALU.
- alu_a[3], alu_b[3]  out  WORD_LEN  registered operands to the ALU.
- alu_out[3]  in  WORD_LEN  combinational ALU result.

## Operation
- FSM states: IDLE, EXEC, RESP.
- Reset values:
  - state IDLE.
  - last_grant=1, so requester 0 wins the first tie.
  - rsp_valid=0, rsp_src=0, rsp_err=0.
  - rsp_out, alu_op, alu_a and alu_b all zero.
- IDLE:
  - Grant is computed combinationally. Exactly one valid wins; if both are valid, the requester != last_grant wins.
  - req_ready[g]=1 only for the granted requester, only in IDLE. The other ready is 0.
  - On handshake, register req_op/req_a/req_b of g into alu_*, set rsp_src=g and last_grant=g, then go to EXEC.
  - If no request is valid, stay in IDLE and hold last_grant.
- EXEC (exactly one cycle): capture alu_out into rsp_out, set rsp_err, go to RESP.
- RESP:
  - rsp_valid=1 and all rsp_* held stable.
  - On rsp_valid&rsp_ready, go to IDLE.
  - req_ready=0 throughout.
- Arithmetic is entirely inside the ALU: Q(IW).(QW), two's complement, no clipping. The block never modifies result bits except under the Configuration rule.
- alu_* hold their last value outside EXEC.
- Requester rules:
  - Hold req_valid and payload stable until ready.
  - Deasserting req_valid before acceptance is legal; the request is simply not issued.
- rst asserted in any state forces the reset values at the next edge. An in-flight result is discarded and never presented.

## Timing
- Edge E0 (request handshake) → EXEC → edge E1 captures result → rsp_valid high from E1 to the handshake edge.
- Request-to-response latency: 2 cycles.
- Minimum 3 cycles per transaction: IDLE, EXEC, RESP with rsp_ready held high.
- req_ready may depend combinationally on both req_valid inputs. It never depends on rsp_ready.
- No request is accepted in the cycle where a response handshake happens; the next accept is at the following edge at the earliest.

## Configuration
- RT_ALU_ARB_OPCHK_EN defined:
  - Opcodes > 2 produce rsp_err=1 and rsp_out forced to all zero.
  - The op is still issued to the ALU, and latency is unchanged.
- RT_ALU_ARB_OPCHK_EN undefined:
  - rsp_err is tied 0.
  - Illegal opcodes return the ALU default, i.e. operand a passed through.

## Test plan
- Single ADD from r0:
  - Stimulus: a=[0x00010000, 0x00020000, 0xFFFF0000], b=[0x00008000, 0x00010000, 0x00010000].
  - Response: rsp_out=[0x00018000, 0x00030000, 0x00000000], rsp_src=0, rsp_valid exactly 2 cycles after accept.
- MUL from r1:
  - Stimulus: a lane0=0x00020000, b lane0=0x00030000.
  - Response: lane0=0x00060000, rsp_src=1.
- Both requesters valid continuously for 4 transactions:
  - Grants alternate 0,1,0,1.
  - No requester is granted twice in a row while the other waits.
- rsp_ready held low for 5 cycles in RESP:
  - rsp_* stable throughout, both req_ready=0.
  - After rsp_ready=1, return to IDLE and a new accept happens on the following edge.
- rst pulsed during EXEC of an r0 SUB:
  - No rsp_valid appears.
  - All outputs are at reset values on the next cycle.
  - With both requesters then valid, r0 is granted first.
- op=4'b0111, a lane0=0x00050000:
  - With the macro: rsp_err=1, rsp_out all zero.
  - Without the macro: rsp_err=0, lane0=0x00050000.
